// File: rtl/i2s_sample_rx.sv
// I2S single-slot receiver: oversamples BCLK/LRCLK/SDATA on clk, deserialises one
// channel MSB first and hands each word to the DSP engine under its ready handshake.
module i2s_sample_rx #(
  parameter int unsigned data_width     = 16,
  parameter int unsigned slot_width     = 32,
  parameter bit          channel_select = 1'b0,
  parameter int unsigned sync_stages    = 2,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_sdata,
  input  logic                  engine_ready,
  output logic [data_width-1:0] sample_out,
  output logic                  sample_ready,
  output logic                  overrun,
  input  logic                  overrun_clear,
  output logic                  frame_error,
  output logic                  active
);

  localparam int unsigned CNT_W = $clog2(slot_width) + 1;
  localparam int unsigned TO_W  = $clog2(timeout_cycles + 1);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SHIFT, S_DRAIN} state_t;

  logic [sync_stages-1:0] r_bclk_sync, r_lrclk_sync, r_sdata_sync;
  logic                   r_bclk_prev, r_lr_prev;
  logic [TO_W-1:0]        r_to_cnt;
  state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [data_width-1:0]  r_shreg, r_word, r_sample_out;
  logic                   r_pending, r_sample_ready, r_overrun, r_frame_error, r_active;

  logic                   w_bclk, w_lrclk, w_sdata, w_e, w_l, w_into_sel, w_to_hit;
  logic                   w_shift, w_done, w_short, w_cnt_clr, w_deliver;
  logic [data_width-1:0]  w_shreg_next, w_word;

  // NOTE: every register below uses non-blocking assignment so all flops update
  // together on the edge regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk_sync  <= '0;
      r_lrclk_sync <= '0;
      r_sdata_sync <= '0;
      r_bclk_prev  <= 1'b0;
    end else begin
      r_bclk_sync  <= {r_bclk_sync[sync_stages-2:0], i2s_bclk};
      r_lrclk_sync <= {r_lrclk_sync[sync_stages-2:0], i2s_lrclk};
      r_sdata_sync <= {r_sdata_sync[sync_stages-2:0], i2s_sdata};
      r_bclk_prev  <= w_bclk;
    end
  end

  assign w_bclk     = r_bclk_sync[sync_stages-1];
  assign w_lrclk    = r_lrclk_sync[sync_stages-1];
  assign w_sdata    = r_sdata_sync[sync_stages-1];
  assign w_e        = w_bclk & ~r_bclk_prev;
  assign w_l        = w_e & (w_lrclk != r_lr_prev);
  assign w_into_sel = (w_lrclk == channel_select);
  // Fires once, on the cycle the idle count would reach timeout_cycles.
  assign w_to_hit   = ~w_e & (r_to_cnt == TO_W'(timeout_cycles - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lr_prev <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (w_e) r_lr_prev <= w_lrclk;
      if (w_e)
        r_to_cnt <= '0;
      else if (r_to_cnt != TO_W'(timeout_cycles))
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_state_next = r_state;
    if (w_to_hit) begin
      w_state_next = S_IDLE;
    end else if (w_e) begin
      // Any LRCLK edge restarts the IDLE decision on the same E, so no frame is lost.
      if (w_l)
        w_state_next = w_into_sel ? S_SKIP : S_IDLE;
      else if (r_state == S_SKIP)
        w_state_next = S_SHIFT;
      else if (r_state == S_SHIFT && r_bit_cnt == CNT_W'(data_width - 1))
        w_state_next = S_DRAIN;
    end
  end

  always_comb begin
    w_shift   = w_e && !w_l && (r_state == S_SHIFT);
    w_done    = w_shift && (r_bit_cnt == CNT_W'(data_width - 1));
    w_short   = w_l && (r_state == S_SKIP || r_state == S_SHIFT);
    w_cnt_clr = w_e && !w_l && (r_state == S_SKIP);
  end

  assign w_shreg_next = (r_shreg << 1) | data_width'(w_sdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else begin
      if (w_cnt_clr)    r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift)      r_shreg   <= w_shreg_next;
    end
  end

  // A word is handed over on the edge after a cycle with engine_ready high; the
  // freshly completed word bypasses the pending register and always wins.
  assign w_word    = w_done ? w_shreg_next : r_word;
  assign w_deliver = (w_done | r_pending) & engine_ready & ~r_sample_ready & ~w_to_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word         <= '0;
      r_pending      <= 1'b0;
      r_sample_out   <= '0;
      r_sample_ready <= 1'b0;
      r_overrun      <= 1'b0;
      r_frame_error  <= 1'b0;
      r_active       <= 1'b0;
    end else begin
      if (w_done) r_word <= w_shreg_next;
      if (w_to_hit || w_deliver) r_pending <= 1'b0;
      else if (w_done)           r_pending <= 1'b1;
      r_sample_ready <= w_deliver;
      if (w_deliver) r_sample_out <= w_word;
      if (w_done && r_pending) r_overrun <= 1'b1;
      else if (overrun_clear)  r_overrun <= 1'b0;
      r_frame_error <= w_short;
      if (w_to_hit)    r_active <= 1'b0;
      else if (w_done) r_active <= 1'b1;
    end
  end

  assign sample_out   = r_sample_out;
  assign sample_ready = r_sample_ready;
  assign overrun      = r_overrun;
  assign frame_error  = r_frame_error;
  assign active       = r_active;

endmodule
